// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the alu_seq registered ALU.
package alu_seq_pkg;

    localparam int unsigned OPND_W = 4;
    localparam int unsigned RES_W  = 8;
    localparam int unsigned OP_W   = 2;

    localparam logic [OP_W-1:0] OP_ADD = 2'd0;
    localparam logic [OP_W-1:0] OP_MUL = 2'd1;
    localparam logic [OP_W-1:0] OP_SUB = 2'd2;
    localparam logic [OP_W-1:0] OP_AND = 2'd3;

    // One operation request: both operands plus the operation select.
    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic [OP_W-1:0]   opcode;
    } alu_req_t;

endpackage

// File: rtl/alu_seq_core.sv
// Combinational operation mux: zero-extends both operands and applies the selected op modulo 256.
module alu_seq_core
    import alu_seq_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic [OP_W-1:0]   opcode,
    output logic [RES_W-1:0]  result_c
);

    logic [RES_W-1:0] a_ext;
    logic [RES_W-1:0] b_ext;

    assign a_ext = RES_W'(a);
    assign b_ext = RES_W'(b);

    // Unknown opcodes fall to the default branch and yield zero.
    always_comb begin
        result_c = '0;
        case (opcode)
            OP_ADD:  result_c = a_ext + b_ext;
            OP_MUL:  result_c = a_ext * b_ext;
            OP_SUB:  result_c = a_ext - b_ext;
            OP_AND:  result_c = RES_W'(a & b);
            default: result_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Registered 4-bit ALU with 8-bit result; ALU_SEQ_INPUT_REG_EN adds an input register stage
// (latency 2 instead of 1).
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic [OPND_W-1:0] A,
    input  logic [OPND_W-1:0] B,
    input  logic [OP_W-1:0]   opcode,
    input  logic              rst,
    input  logic              clk,
    output logic [RES_W-1:0]  out
);

    alu_req_t         req;
    logic [RES_W-1:0] result_c;

`ifdef ALU_SEQ_INPUT_REG_EN
    alu_req_t req_q;

    // Input capture stage; the result is computed from these copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '0;
        end else begin
            req_q.a      <= A;
            req_q.b      <= B;
            req_q.opcode <= opcode;
        end
    end

    assign req = req_q;
`else
    assign req.a      = A;
    assign req.b      = B;
    assign req.opcode = opcode;
`endif

    alu_seq_core u_core (
        .a        (req.a),
        .b        (req.b),
        .opcode   (req.opcode),
        .result_c (result_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= result_c;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and random self-checking bench for alu_seq (either ALU_SEQ_INPUT_REG_EN build).
module tb_alu_seq;

`ifdef ALU_SEQ_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] A = 4'd0;
    logic [3:0] B = 4'd0;
    logic [1:0] opcode = 2'd0;
    logic [7:0] out;

    int checks = 0;
    int errors = 0;

    alu_seq dut (
        .A      (A),
        .B      (B),
        .opcode (opcode),
        .rst    (rst),
        .clk    (clk),
        .out    (out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [1:0] op);
        logic [7:0] xa;
        logic [7:0] xb;
        xa = {4'b0000, a};
        xb = {4'b0000, b};
        case (op)
            2'd0:    return xa + xb;
            2'd1:    return xa * xb;
            2'd2:    return xa - xb;
            default: return {4'b0000, a & b};
        endcase
    endfunction

    // Drive at a negedge, let two rising edges pass, sample at the following negedge.
    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        @(negedge clk);
        A = a;
        B = b;
        opcode = op;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        A = 4'd5;
        B = 4'd5;
        opcode = 2'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (out !== 8'd0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: out=%0d expected=0", i, out);
            end
        end
    endtask

    task automatic test_release;
        @(negedge clk);
        A = 4'd9;
        B = 4'd7;
        opcode = 2'd0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out !== ((LAT == 1) ? 8'd16 : 8'd0)) begin
            errors++;
            $display("FAIL release_first: out=%0d expected=%0d", out, (LAT == 1) ? 16 : 0);
        end
        @(negedge clk);
        checks++;
        if (out !== 8'd16) begin
            errors++;
            $display("FAIL release_second: out=%0d expected=16", out);
        end
    endtask

    task automatic test_add_and;
        apply(4'd9, 4'd7, 2'd0);
        checks++;
        if (out !== 8'd16) begin errors++; $display("FAIL add_9_7: out=%0d expected=16", out); end
        apply(4'd15, 4'd15, 2'd0);
        checks++;
        if (out !== 8'd30) begin errors++; $display("FAIL add_15_15: out=%0d expected=30", out); end
        apply(4'd12, 4'd10, 2'd3);
        checks++;
        if (out !== 8'd8) begin errors++; $display("FAIL and_12_10: out=%0d expected=8", out); end
    endtask

    task automatic test_mul;
        apply(4'd0, 4'd9, 2'd1);
        checks++;
        if (out !== 8'd0) begin errors++; $display("FAIL mul_0_9: out=%0d expected=0", out); end
        apply(4'd15, 4'd15, 2'd1);
        checks++;
        if (out !== 8'd225) begin errors++; $display("FAIL mul_15_15: out=%0d expected=225", out); end
    endtask

    task automatic test_sub;
        apply(4'd5, 4'd3, 2'd2);
        checks++;
        if (out !== 8'd2) begin errors++; $display("FAIL sub_5_3: out=%0d expected=2", out); end
        apply(4'd3, 4'd5, 2'd2);
        checks++;
        if (out !== 8'd254) begin errors++; $display("FAIL sub_3_5: out=%0d expected=254", out); end
        apply(4'd0, 4'd15, 2'd2);
        checks++;
        if (out !== 8'd241) begin errors++; $display("FAIL sub_0_15: out=%0d expected=241", out); end
    endtask

    task automatic test_latency;
        apply(4'd1, 4'd1, 2'd0);
        checks++;
        if (out !== 8'd2) begin errors++; $display("FAIL lat_setup: out=%0d expected=2", out); end
        A = 4'd9;
        B = 4'd7;
        opcode = 2'd0;
        @(negedge clk);
        checks++;
        if (out !== ((LAT == 1) ? 8'd16 : 8'd2)) begin
            errors++;
            $display("FAIL lat_edge1: out=%0d expected=%0d", out, (LAT == 1) ? 16 : 2);
        end
        @(negedge clk);
        checks++;
        if (out !== 8'd16) begin errors++; $display("FAIL lat_edge2: out=%0d expected=16", out); end
    endtask

    task automatic test_async_reset;
        apply(4'd15, 4'd15, 2'd1);
        checks++;
        if (out !== 8'd225) begin errors++; $display("FAIL async_pre: out=%0d expected=225", out); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out !== 8'd0) begin errors++; $display("FAIL async_clear: out=%0d expected=0", out); end
        @(negedge clk);
        checks++;
        if (out !== 8'd0) begin errors++; $display("FAIL async_hold: out=%0d expected=0", out); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [1:0] rop;
        logic [7:0] exp_v;
        for (int i = 0; i < 100; i++) begin
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            rop = 2'($urandom_range(0, 3));
            apply(ra, rb, rop);
            exp_v = ref_model(ra, rb, rop);
            checks++;
            if (out !== exp_v) begin
                errors++;
                $display("FAIL random iter %0d a=%0d b=%0d op=%0d: out=%0d expected=%0d",
                         i, ra, rb, rop, out, exp_v);
                break;
            end
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_add_and();
        test_mul();
        test_sub();
        test_latency();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
